// File: rtl/weight_load_sequencer.sv
// Streams one layer of weights out of the synchronous weight RAM in unit-major order and
// steers each word to its neuron unit with a one-hot strobe and slot index, then pulses sum_trigger.
//
// state | meaning
// IDLE  | waiting for start; an out-of-range layer pulses err
// READ  | one RAM read per cycle, read tags enter the latency delay line
// DRAIN | reads done, waiting for the last tag to leave the delay line
// TRIG  | one-cycle sum_trigger, last busy cycle
module weight_load_sequencer #(
  parameter int DATA_W           = 8,
  parameter int NUM_UNITS        = 4,
  parameter int WEIGHTS_PER_UNIT = 4,
  parameter int NUM_LAYERS       = 3,
  parameter int ADDR_W           = 10,
  parameter int RAM_LATENCY      = 1,
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int UNIT_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int SLOT_W  = (WEIGHTS_PER_UNIT > 1) ? $clog2(WEIGHTS_PER_UNIT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LAYER_W-1:0]   layer,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_rd,
  input  logic [DATA_W-1:0]    ram_data,
  output logic [DATA_W-1:0]    weight,
  output logic [NUM_UNITS-1:0] unit_write,
  output logic [SLOT_W-1:0]    unit_waddr,
  output logic                 busy,
  output logic                 sum_trigger,
  output logic                 err
);

  localparam int N = NUM_UNITS * WEIGHTS_PER_UNIT;
  localparam bit ADDR_FITS = (longint'(NUM_LAYERS) * longint'(N)) <= (longint'(1) << ADDR_W);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, TRIG} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [UNIT_W-1:0]   unit_q;
  logic [SLOT_W-1:0]   slot_q;
  logic                bad_layer, accept, last_slot, last_read, rd_now;
  logic                tap_v, pending;
  logic [UNIT_W-1:0]   tap_unit;
  logic [SLOT_W-1:0]   tap_slot;

  assign bad_layer = 32'(layer) >= 32'(NUM_LAYERS);
  assign accept    = (state == IDLE) && start && !bad_layer;
  assign last_slot = slot_q == SLOT_W'(WEIGHTS_PER_UNIT - 1);
  assign last_read = last_slot && (unit_q == UNIT_W'(NUM_UNITS - 1));
  assign rd_now    = state == READ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = READ;
      READ:  if (last_read) state_nxt = DRAIN;
      DRAIN: if (!pending) state_nxt = TRIG;
      TRIG:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The captured layer lives on as the running read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      unit_q <= '0;
      slot_q <= '0;
      err    <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && bad_layer;
      if (accept) begin
        addr_q <= ADDR_W'(layer) * ADDR_W'(N);
        unit_q <= '0;
        slot_q <= '0;
      end else if (rd_now) begin
        addr_q <= addr_q + 1'b1;
        if (last_slot) begin
          slot_q <= '0;
          unit_q <= unit_q + 1'b1;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
      end
    end
  end

  // Tags ride alongside the RAM pipeline so they line up with ram_data when it is sampled.
  generate
    if (RAM_LATENCY > 1) begin : g_delay
      localparam int D = RAM_LATENCY - 1;
      logic [D-1:0]      dv;
      logic [UNIT_W-1:0] du [D];
      logic [SLOT_W-1:0] ds [D];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dv <= '0;
          for (int i = 0; i < D; i++) begin
            du[i] <= '0;
            ds[i] <= '0;
          end
        end else begin
          dv[0] <= rd_now;
          du[0] <= unit_q;
          ds[0] <= slot_q;
          for (int i = 1; i < D; i++) begin
            dv[i] <= dv[i-1];
            du[i] <= du[i-1];
            ds[i] <= ds[i-1];
          end
        end
      end

      assign tap_v    = dv[D-1];
      assign tap_unit = du[D-1];
      assign tap_slot = ds[D-1];
      assign pending  = |dv;
    end else begin : g_direct
      assign tap_v    = rd_now;
      assign tap_unit = unit_q;
      assign tap_slot = slot_q;
      assign pending  = rd_now;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight     <= '0;
      unit_write <= '0;
      unit_waddr <= '0;
    end else begin
      unit_write <= tap_v ? (NUM_UNITS'(1) << tap_unit) : '0;
      if (tap_v) begin
        weight     <= ram_data;
        unit_waddr <= tap_slot;
      end
    end
  end

  assign ram_rd      = rd_now;
  assign ram_addr    = rd_now ? addr_q : '0;
  assign busy        = state != IDLE;
  assign sum_trigger = state == TRIG;

  a_addr_fits: assert property (@(posedge clk) ADDR_FITS)
    else $error("weight_load_sequencer: layers do not fit in ADDR_W");

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench: a default-parameter instance (latency 1, RAM data = address) and a
// latency-3, 8-unit by 2-weight instance, each checked cycle by cycle against hand-derived timing.
module tb_weight_load_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a, ram_rd_a, busy_a, sum_trigger_a, err_a;
  logic [1:0] layer_a, unit_waddr_a;
  logic [9:0] ram_addr_a;
  logic [7:0] ram_data_a, weight_a;
  logic [3:0] unit_write_a;

  logic       start_b, ram_rd_b, busy_b, sum_trigger_b, err_b;
  logic [1:0] layer_b;
  logic [0:0] unit_waddr_b;
  logic [9:0] ram_addr_b, d1_b, d2_b;
  logic [7:0] ram_data_b, weight_b, unit_write_b;

  int checks = 0;
  int errors = 0;

  weight_load_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .layer(layer_a),
    .ram_addr(ram_addr_a), .ram_rd(ram_rd_a), .ram_data(ram_data_a),
    .weight(weight_a), .unit_write(unit_write_a), .unit_waddr(unit_waddr_a),
    .busy(busy_a), .sum_trigger(sum_trigger_a), .err(err_a)
  );

  weight_load_sequencer #(.NUM_UNITS(8), .WEIGHTS_PER_UNIT(2), .RAM_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .layer(layer_b),
    .ram_addr(ram_addr_b), .ram_rd(ram_rd_b), .ram_data(ram_data_b),
    .weight(weight_b), .unit_write(unit_write_b), .unit_waddr(unit_waddr_b),
    .busy(busy_b), .sum_trigger(sum_trigger_b), .err(err_b)
  );

  // RAM models return the low address byte: combinational for latency 1, two-cycle delay for latency 3.
  assign ram_data_a = ram_addr_a[7:0];
  always @(posedge clk) begin
    d1_b <= ram_addr_b;
    d2_b <= d1_b;
  end
  assign ram_data_b = d2_b[7:0];

  task automatic test_reset();
    logic [7:0]  exp_ctrl_a;
    logic [11:0] exp_ctrl_b;
    reset = 1'b1;
    start_a = 1'b0; layer_a = 2'd0;
    start_b = 1'b0; layer_b = 2'd0;
    exp_ctrl_a = '0;
    exp_ctrl_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_rd_a, busy_a, sum_trigger_a, err_a, unit_write_a} !== exp_ctrl_a ||
        ram_addr_a !== 10'd0 || weight_a !== 8'd0 || unit_waddr_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_a got ctrl=%b addr=%0d w=%0d wa=%0d exp all zero",
               {ram_rd_a, busy_a, sum_trigger_a, err_a, unit_write_a}, ram_addr_a, weight_a, unit_waddr_a);
    end
    checks++;
    if ({ram_rd_b, busy_b, sum_trigger_b, err_b, unit_write_b} !== exp_ctrl_b ||
        ram_addr_b !== 10'd0 || weight_b !== 8'd0 || unit_waddr_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got ctrl=%b addr=%0d w=%0d exp all zero",
               {ram_rd_b, busy_b, sum_trigger_b, err_b, unit_write_b}, ram_addr_b, weight_b);
    end
    reset = 1'b0;
  endtask

  // Full load on instance A; inject adds ignored starts mid-load and on the sum_trigger cycle.
  task automatic test_load_a(input int lay, input bit inject);
    int base, k, ntrig;
    logic [7:0] exp_ctrl, got_ctrl;
    logic [3:0] exp_wr;
    base = lay * 16;
    ntrig = 0;
    @(negedge clk);
    start_a = 1'b1; layer_a = 2'(lay);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      k = i - 2;
      exp_wr = (k >= 0 && k < 16) ? (4'd1 << (k / 4)) : 4'd0;
      exp_ctrl = {(i <= 16), (i <= 18), (i == 18), 1'b0, exp_wr};
      got_ctrl = {ram_rd_a, busy_a, sum_trigger_a, err_a, unit_write_a};
      if (sum_trigger_a === 1'b1) ntrig++;
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL load_a%0d_ctrl cyc=%0d got=%b exp=%b", lay, i, got_ctrl, exp_ctrl);
      end
      if (i <= 16) begin
        checks++;
        if (ram_addr_a !== 10'(base + i - 1)) begin
          errors++;
          $display("FAIL load_a%0d_addr cyc=%0d got=%0d exp=%0d", lay, i, ram_addr_a, base + i - 1);
        end
      end
      if (exp_wr != 4'd0) begin
        checks++;
        if (weight_a !== 8'(base + k) || unit_waddr_a !== 2'(k % 4)) begin
          errors++;
          $display("FAIL load_a%0d_data cyc=%0d got w=%0d wa=%0d exp w=%0d wa=%0d",
                   lay, i, weight_a, unit_waddr_a, base + k, k % 4);
        end
      end
      start_a = inject && (i == 5 || i == 18);
      if (i == 3 || inject) layer_a = 2'd1;
    end
    start_a = 1'b0;
    checks++;
    if (ntrig != 1) begin
      errors++;
      $display("FAIL load_a%0d_trig_count got=%0d exp=1", lay, ntrig);
    end
  endtask

  task automatic test_latency3();
    int k;
    logic [11:0] exp_ctrl, got_ctrl;
    logic [7:0]  exp_wr;
    @(negedge clk);
    start_b = 1'b1; layer_b = 2'd1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      k = i - 4;
      exp_wr = (k >= 0 && k < 16) ? (8'd1 << (k / 2)) : 8'd0;
      exp_ctrl = {(i <= 16), (i <= 20), (i == 20), 1'b0, exp_wr};
      got_ctrl = {ram_rd_b, busy_b, sum_trigger_b, err_b, unit_write_b};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL lat3_ctrl cyc=%0d got=%b exp=%b", i, got_ctrl, exp_ctrl);
      end
      if (i <= 16) begin
        checks++;
        if (ram_addr_b !== 10'(15 + i)) begin
          errors++;
          $display("FAIL lat3_addr cyc=%0d got=%0d exp=%0d", i, ram_addr_b, 15 + i);
        end
      end
      if (exp_wr != 8'd0) begin
        checks++;
        if (weight_b !== 8'(16 + k) || unit_waddr_b !== 1'(k % 2)) begin
          errors++;
          $display("FAIL lat3_data cyc=%0d got w=%0d wa=%0d exp w=%0d wa=%0d",
                   i, weight_b, unit_waddr_b, 16 + k, k % 2);
        end
      end
    end
  endtask

  task automatic test_bad_layer();
    logic [7:0] exp_ctrl, got_ctrl;
    @(negedge clk);
    start_a = 1'b1; layer_a = 2'd3;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      exp_ctrl = {3'b000, (i == 1), 4'b0000};
      got_ctrl = {ram_rd_a, busy_a, sum_trigger_a, err_a, unit_write_a};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL bad_layer cyc=%0d got=%b exp=%b", i, got_ctrl, exp_ctrl);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    start_a = 1'b1; layer_a = 2'd0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    checks++;
    if (ram_addr_a !== 10'd6 || ram_rd_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_before_reset got addr=%0d rd=%b exp addr=6 rd=1", ram_addr_a, ram_rd_a);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ram_rd_a, busy_a, sum_trigger_a, err_a, unit_write_a} !== 8'd0 ||
        ram_addr_a !== 10'd0 || weight_a !== 8'd0 || unit_waddr_a !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got ctrl=%b addr=%0d w=%0d exp all zero",
               {ram_rd_a, busy_a, sum_trigger_a, err_a, unit_write_a}, ram_addr_a, weight_a);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_rd_a, busy_a, sum_trigger_a, unit_write_a} !== 7'd0) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got=%b exp=0", i,
                 {ram_rd_a, busy_a, sum_trigger_a, unit_write_a});
      end
    end
    test_load_a(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int ntrig;
    ntrig = 0;
    @(negedge clk);
    start_a = 1'b1; layer_a = 2'd0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    checks++;
    if (sum_trigger_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_trig got=%b exp=1", sum_trigger_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got busy=%b exp=0", busy_a);
    end
    start_a = 1'b1; layer_a = 2'd2;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || ram_rd_a !== 1'b1 || ram_addr_a !== 10'd32) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b rd=%b addr=%0d exp 1 1 32", busy_a, ram_rd_a, ram_addr_a);
    end
    for (int i = 21; i <= 40; i++) begin
      @(negedge clk);
      if (sum_trigger_a === 1'b1) ntrig++;
      if (i == 36) begin
        checks++;
        if (unit_write_a !== 4'b1000 || weight_a !== 8'd47 || unit_waddr_a !== 2'd3) begin
          errors++;
          $display("FAIL b2b_last_strobe got uw=%b w=%0d wa=%0d exp 1000 47 3",
                   unit_write_a, weight_a, unit_waddr_a);
        end
      end
      if (i == 37) begin
        checks++;
        if (sum_trigger_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_trig got=%b exp=1", sum_trigger_a);
        end
      end
    end
    checks++;
    if (ntrig != 1) begin
      errors++;
      $display("FAIL b2b_trig_count got=%0d exp=1", ntrig);
    end
  endtask

  initial begin
    test_reset();
    test_load_a(0, 1'b0);
    test_load_a(2, 1'b0);
    test_latency3();
    test_load_a(1, 1'b1);
    test_bad_layer();
    test_reset_mid_load();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
